// File: rtl/despachador_demux_pkg.sv
// Shared definitions for the round-robin dispatcher: demux selector
// encodings, preference FSM states and the target-choice helper.
package despachador_demux_pkg;

    localparam logic [1:0] SEL_NINGUNO = 2'b00;
    localparam logic [1:0] SEL_CANAL1  = 2'b01;
    localparam logic [1:0] SEL_CANAL2  = 2'b10;

    typedef enum logic {
        PREF1 = 1'b0,
        PREF2 = 1'b1
    } estado_t;

    // Preferred channel wins when free, otherwise fall back to the other
    // channel, otherwise report no target.
    function automatic logic [1:0] elegir_objetivo(
        input logic       i_libre_pref,
        input logic       i_libre_otro,
        input logic [1:0] i_sel_pref,
        input logic [1:0] i_sel_otro
    );
        logic [1:0] w_sel;
        if (i_libre_pref) begin
            w_sel = i_sel_pref;
        end else if (i_libre_otro) begin
            w_sel = i_sel_otro;
        end else begin
            w_sel = SEL_NINGUNO;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/despachador_demux_registro_canal.sv
// One output channel: one-entry holding register, its full flag and a
// wrapping count of words handed to the downstream consumer.
module registro_canal #(
    parameter int ANCHO     = 8,
    parameter int ANCHO_CNT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_carga,
    input  logic [ANCHO-1:0]     i_dato,
    input  logic                 i_listo,
    output logic [ANCHO-1:0]     o_dato,
    output logic                 o_valido,
    output logic [ANCHO_CNT-1:0] o_cuenta
);

    localparam logic [ANCHO_CNT-1:0] CNT_UNO = {{(ANCHO_CNT-1){1'b0}}, 1'b1};

    logic [ANCHO-1:0]     r_dato;
    logic                 r_valido;
    logic [ANCHO_CNT-1:0] r_cuenta;
    logic                 w_drena;

    // A word leaves the register whenever it is full and the consumer is ready.
    assign w_drena = r_valido && i_listo;

    // Holding register: a load wins over a drain, so a same-cycle drain+load keeps it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dato   <= {ANCHO{1'b0}};
            r_valido <= 1'b0;
        end else if (i_carga) begin
            r_dato   <= i_dato;
            r_valido <= 1'b1;
        end else if (w_drena) begin
            r_dato   <= r_dato;
            r_valido <= 1'b0;
        end else begin
            r_dato   <= r_dato;
            r_valido <= r_valido;
        end
    end

    // Delivered-word counter, wraps naturally at 2^ANCHO_CNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cuenta <= {ANCHO_CNT{1'b0}};
        end else if (w_drena) begin
            r_cuenta <= r_cuenta + CNT_UNO;
        end else begin
            r_cuenta <= r_cuenta;
        end
    end

    assign o_dato   = r_dato;
    assign o_valido = r_valido;
    assign o_cuenta = r_cuenta;

endmodule

// File: rtl/despachador_demux.sv
// Round-robin dispatcher feeding a 1-to-2 demux: alternates accepted words
// between two holding registers, skipping a channel that cannot take one.
module despachador_demux
    import despachador_demux_pkg::*;
#(
    parameter int ANCHO     = 8,
    parameter int ANCHO_CNT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ANCHO-1:0]     entrada_dato,
    input  logic                 entrada_valido,
    output logic                 entrada_listo,
    output logic [ANCHO-1:0]     salida1_dato,
    output logic                 salida1_valido,
    input  logic                 salida1_listo,
    output logic [ANCHO-1:0]     salida2_dato,
    output logic                 salida2_valido,
    input  logic                 salida2_listo,
    output logic [1:0]           selector,
    output logic [ANCHO_CNT-1:0] cuenta1,
    output logic [ANCHO_CNT-1:0] cuenta2
);

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic       w_libre1;
    logic       w_libre2;
    logic [1:0] w_objetivo;
    logic       w_acepta;
    logic       w_carga1;
    logic       w_carga2;

    // A channel is free when empty or when its current word drains this cycle.
    assign w_libre1 = !salida1_valido || salida1_listo;
    assign w_libre2 = !salida2_valido || salida2_listo;

    // Preference state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= PREF1;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Target selection, handshake outputs, load strobes and next preference.
    always_comb begin
        w_objetivo    = SEL_NINGUNO;
        w_estado_sig  = r_estado;
        entrada_listo = 1'b0;
        selector      = SEL_NINGUNO;
        w_acepta      = 1'b0;
        w_carga1      = 1'b0;
        w_carga2      = 1'b0;

        if (rst) begin
            w_objetivo = SEL_NINGUNO;
        end else begin
            case (r_estado)
                PREF1:   w_objetivo = elegir_objetivo(w_libre1, w_libre2, SEL_CANAL1, SEL_CANAL2);
                PREF2:   w_objetivo = elegir_objetivo(w_libre2, w_libre1, SEL_CANAL2, SEL_CANAL1);
                default: w_objetivo = SEL_NINGUNO;
            endcase
        end

        entrada_listo = (w_objetivo != SEL_NINGUNO);
        w_acepta      = entrada_valido && entrada_listo;

        if (w_acepta) begin
            selector = w_objetivo;
            w_carga1 = (w_objetivo == SEL_CANAL1);
            w_carga2 = (w_objetivo == SEL_CANAL2);
            // Next preference is the channel opposite the one just used.
            if (w_carga1) begin
                w_estado_sig = PREF2;
            end else begin
                w_estado_sig = PREF1;
            end
        end else begin
            selector     = SEL_NINGUNO;
            w_estado_sig = r_estado;
        end
    end

    registro_canal #(
        .ANCHO     (ANCHO),
        .ANCHO_CNT (ANCHO_CNT)
    ) u_canal1 (
        .clk      (clk),
        .rst      (rst),
        .i_carga  (w_carga1),
        .i_dato   (entrada_dato),
        .i_listo  (salida1_listo),
        .o_dato   (salida1_dato),
        .o_valido (salida1_valido),
        .o_cuenta (cuenta1)
    );

    registro_canal #(
        .ANCHO     (ANCHO),
        .ANCHO_CNT (ANCHO_CNT)
    ) u_canal2 (
        .clk      (clk),
        .rst      (rst),
        .i_carga  (w_carga2),
        .i_dato   (entrada_dato),
        .i_listo  (salida2_listo),
        .o_dato   (salida2_dato),
        .o_valido (salida2_valido),
        .o_cuenta (cuenta2)
    );

endmodule

// File: doc/despachador_demux.md
# despachador_demux

Sequential round-robin dispatcher sitting directly upstream of the 1-to-2 demultiplexer. It accepts a data stream over a valid/ready handshake and alternates the words between two output channels, each with a one-entry holding register. It drives the 2-bit demux selector and skips a blocked channel when the other can take the word. Per-channel word counters support debug and verification.

## Interface
Parameters:
- ANCHO, 8, data width in bits.
- ANCHO_CNT, 16, width of each per-channel word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- entrada_dato  input  ANCHO  incoming word.
- entrada_valido  input  1  incoming word valid.
- entrada_listo  output  1  dispatcher can accept this cycle.
- salida1_dato  output  ANCHO  channel 1 holding register.
- salida1_valido  output  1  channel 1 register full.
- salida1_listo  input  1  channel 1 consumer accepts.
- salida2_dato  output  ANCHO  channel 2 holding register.
- salida2_valido  output  1  channel 2 register full.
- salida2_listo  input  1  channel 2 consumer accepts.
- selector  output  2  demux select: 2'b01 means channel 1, 2'b10 means channel 2, 2'b00 means no transfer.
- cuenta1  output  ANCHO_CNT  words delivered on channel 1.
- cuenta2  output  ANCHO_CNT  words delivered on channel 2.

## Operation
- Channel N can take a word when `libreN = !salidaN_valido || salidaN_listo`, meaning the register is empty or draining this cycle.
- Two-state preference FSM:
  - PREF1: channel 1 is preferred.
  - PREF2: channel 2 is preferred.
- Target selection:
  - The preferred channel is the target if it is free.
  - Otherwise the other channel is the target if it is free.
  - Otherwise there is no target.
- Outputs derived from the target:
  - `entrada_listo` = a target exists.
  - `selector` = the target encoding when `entrada_valido` is high and a target exists; 2'b00 otherwise.
- Accept occurs when `entrada_valido && entrada_listo`. On accept:
  - The target register loads `entrada_dato` and its valido is set.
  - The FSM moves to prefer the channel opposite the one used. Skipping a blocked channel therefore keeps the alternation relative to the last use.
- No accept: the FSM holds its state.
- Drain: `salidaN_valido && salidaN_listo` with no new load into N clears `salidaN_valido`. The data bits keep their last value.
- Drain and load in the same cycle on the same channel: valido stays 1 and the data takes the new word.
- Counters: `cuentaN` increments by one on every drain of channel N. Counters wrap modulo 2^ANCHO_CNT with no saturation.
- A word is never duplicated, dropped or reordered within a channel.
- Data and valid outputs are registered. `entrada_listo` and `selector` are combinational from registered state plus `salidaN_listo` and `entrada_valido`. There is no combinational path from `entrada_dato` to any output.

## Timing
- Reset state: FSM = PREF1, both valido = 0, both data = 0, both counters = 0.
- During reset, `entrada_listo` = 0 and `selector` = 2'b00.
- Reset asserted mid-transfer discards held words immediately; nothing is delivered afterward.
- The first accept is possible on the first rising edge after rst deasserts.
- Latency: a word accepted at edge k is visible on `salidaN_dato`/`salidaN_valido` after edge k. Minimum latency is 1 cycle.
- Throughput: 1 word per cycle when both consumers are always ready, alternating 1, 2, 1, 2, …
- Both channels full and neither consumer ready: `entrada_listo` = 0 and `selector` = 2'b00.
- Producer rule: the producer must hold `entrada_dato` and `entrada_valido` stable until it sees `entrada_listo` high.

## Structure
- Shared package/include file for the codebase: selector encodings SEL_NINGUNO = 2'b00, SEL_CANAL1 = 2'b01, SEL_CANAL2 = 2'b10, and the FSM state encodings PREF1/PREF2.
- One natural sub-module, `registro_canal`: the holding register plus valido flag plus counter, parameterised by ANCHO and ANCHO_CNT, instantiated twice.
- The top level contains the FSM, target selection and selector decode.

## Test plan
- Reset check: hold rst for 3 cycles with `entrada_valido` = 1. Required: all outputs at reset values, `entrada_listo` = 0, `selector` = 00, no loads.
- Streaming: both `listo` = 1, send 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required:
  - Channel 1 receives 0x11 then 0x33; channel 2 receives 0x22 then 0x44.
  - `selector` sequence is 01, 10, 01, 10.
  - `cuenta1` = `cuenta2` = 2.
- Skip of blocked channel: `salida1_listo` = 0 with channel 1 full, FSM in PREF1, send 0xA5. Required: 0xA5 goes to channel 2, `selector` = 10, FSM ends in PREF1.
- Full backpressure: both channels full, both `listo` = 0, `entrada_valido` = 1 for 5 cycles. Required:
  - `entrada_listo` = 0, `selector` = 00 throughout, data held.
  - Raising `salida2_listo` gives accept to channel 2 in the same cycle.
- Counter wrap (ANCHO_CNT = 4): deliver 17 words on channel 1. Required: `cuenta1` = 1.
- Reset mid-operation: assert rst while both channels are full. Required: both valido drop to 0 immediately (asynchronously); after release, the first word goes to channel 1.
